// File: rtl/ita_gelu_requant.sv
// GELU-output requantizer: 2-stage elastic pipeline computing sat(round(data*mult >>> shift) + add) to int8.
// Optional saturation event counter enabled by defining SAT_CNT_EN.
`timescale 1ns/1ps
module ita_gelu_requant #(
    parameter int IN_WIDTH    = 26,
    parameter int MULT_WIDTH  = 8,
    parameter int SHIFT_WIDTH = 5,
    parameter int ADD_WIDTH   = 8,
    parameter int OUT_WIDTH   = 8,
    parameter int CNT_WIDTH   = 16
) (
    input  logic                        clk_i,
    input  logic                        rst_i,
    input  logic                        valid_i,
    output logic                        ready_o,
    input  logic signed [IN_WIDTH-1:0]  data_i,
    input  logic [MULT_WIDTH-1:0]       mult_i,
    input  logic [SHIFT_WIDTH-1:0]      shift_i,
    input  logic signed [ADD_WIDTH-1:0] add_i,
    output logic                        valid_o,
    input  logic                        ready_i,
    output logic signed [OUT_WIDTH-1:0] data_o,
    output logic                        sat_o,
    output logic [CNT_WIDTH-1:0]        sat_count_o
);

    localparam int PROD_W = IN_WIDTH + MULT_WIDTH + 1;
    localparam int SUM_W  = PROD_W + 1;
    localparam logic signed [SUM_W-1:0] OUT_MAX = (SUM_W'(1) <<< (OUT_WIDTH - 1)) - SUM_W'(1);
    localparam logic signed [SUM_W-1:0] OUT_MIN = ~OUT_MAX;

    // Round half toward +inf, then arithmetic shift; widened so nothing wraps.
    function automatic logic signed [SUM_W-1:0] round_shift(
        input logic signed [PROD_W-1:0]  prod,
        input logic [SHIFT_WIDTH-1:0]    shift
    );
        logic signed [SUM_W-1:0] rnd;
        rnd = '0;
        if (shift != '0) rnd = SUM_W'(1) <<< (shift - 1'b1);
        return (SUM_W'(prod) + rnd) >>> shift;
    endfunction

    // Returns {clipped, value}.
    function automatic logic [OUT_WIDTH:0] saturate(input logic signed [SUM_W-1:0] s);
        if (s > OUT_MAX)      return {1'b1, OUT_MAX[OUT_WIDTH-1:0]};
        else if (s < OUT_MIN) return {1'b1, OUT_MIN[OUT_WIDTH-1:0]};
        else                  return {1'b0, s[OUT_WIDTH-1:0]};
    endfunction

    logic                        vld_p1, vld_p2;
    logic signed [PROD_W-1:0]    prod_p1;
    logic [SHIFT_WIDTH-1:0]      shift_p1;
    logic signed [ADD_WIDTH-1:0] add_p1;
    logic                        s1_load, s2_load;
    logic signed [PROD_W-1:0]    data_ext, mult_ext, prod_c;
    logic signed [SUM_W-1:0]     sum_c;
    logic [OUT_WIDTH:0]          sat_c;

    assign s2_load = !vld_p2 || ready_i;
    assign s1_load = !vld_p1 || s2_load;
    assign ready_o = !rst_i && s1_load;
    assign valid_o = vld_p2;

    assign data_ext = PROD_W'(data_i);
    assign mult_ext = {{(PROD_W - MULT_WIDTH){1'b0}}, mult_i};
    assign prod_c   = data_ext * mult_ext;

    // Stage 1: exact product plus the element's own requant constants
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i)        vld_p1 <= 1'b0;
        else if (s1_load) vld_p1 <= valid_i;
    end

    always_ff @(posedge clk_i) begin
        if (s1_load && valid_i) begin
            prod_p1  <= prod_c;
            shift_p1 <= shift_i;
            add_p1   <= add_i;
        end
    end

    assign sum_c = round_shift(prod_p1, shift_p1) + SUM_W'(add_p1);
    assign sat_c = saturate(sum_c);

    // Stage 2: output register; data only updates when a valid element moves in
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            vld_p2 <= 1'b0;
            data_o <= '0;
            sat_o  <= 1'b0;
        end else if (s2_load) begin
            vld_p2 <= vld_p1;
            if (vld_p1) begin
                data_o <= sat_c[OUT_WIDTH-1:0];
                sat_o  <= sat_c[OUT_WIDTH];
            end
        end
    end

`ifdef SAT_CNT_EN
    logic [CNT_WIDTH-1:0] sat_count;

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i)
            sat_count <= '0;
        else if (vld_p2 && ready_i && sat_o && (sat_count != '1))
            sat_count <= sat_count + 1'b1;
    end

    assign sat_count_o = sat_count;
`else
    assign sat_count_o = '0;
`endif

endmodule
